// File: rtl/layer1_host_if.sv
// Host-side front end for the layer-1 engine: packs 16 input bytes into the
// 128-bit pixel vector, runs start/done, then streams the 48 outputs as 12 bytes.
module layer1_host_if #(
   parameter int unsigned N_PIX = 64,
   parameter int unsigned N_OUT = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [7:0]           in_byte,
   output logic                 in_ready,
   output logic [2*N_PIX-1:0]   pixels_flat,
   output logic                 l1_start,
   input  logic                 l1_done,
   input  logic                 l1_busy,
   output logic [5:0]           l1_read_addr,
   input  logic [1:0]           l1_read_data,
   output logic                 out_valid,
   output logic [7:0]           out_byte,
   input  logic                 out_ready,
   output logic                 frame_done
);

   localparam int unsigned N_IN_BYTES  = N_PIX / 4;
   localparam int unsigned N_OUT_BYTES = N_OUT / 4;

   typedef enum logic [2:0] {
      S_LOAD,
      S_START,
      S_RELEASE,
      S_READ,
      S_SEND
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] byte_cnt;
   logic [5:0] rd_idx;
   logic [7:0] pack, pack_nxt;
   logic       last_in, last_cap, last_out;
   logic       unused_busy;

   assign unused_busy  = l1_busy;
   assign l1_read_addr = rd_idx;
   assign last_in      = (byte_cnt == 4'(N_IN_BYTES - 1));
   assign last_cap     = (rd_idx[1:0] == 2'd3);
   assign last_out     = (byte_cnt == 4'(N_OUT_BYTES - 1));

   always_comb begin
      pack_nxt = pack;
      pack_nxt[{rd_idx[1:0], 1'b0} +: 2] = l1_read_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      l1_start   = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && last_in) state_nxt = S_START;
         end
         S_START: begin
            l1_start = 1'b1;
            if (l1_done) state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (!l1_done) state_nxt = S_READ;
         end
         S_READ: begin
            if (last_cap) state_nxt = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               frame_done = last_out;
               state_nxt  = last_out ? S_LOAD : S_READ;
            end
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // byte_cnt counts input bytes in LOAD, then output bytes in READ/SEND
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt    <= '0;
         rd_idx      <= '0;
         pack        <= '0;
         pixels_flat <= '0;
         out_valid   <= 1'b0;
         out_byte    <= '0;
      end else begin
         unique case (state)
            S_LOAD: begin
               if (in_valid) begin
                  pixels_flat[{byte_cnt, 3'b000} +: 8] <= in_byte;
                  byte_cnt <= last_in ? '0 : byte_cnt + 4'd1;
               end
            end
            S_START: ;
            S_RELEASE: begin
               byte_cnt <= '0;
               rd_idx   <= '0;
            end
            S_READ: begin
               pack   <= pack_nxt;
               rd_idx <= (rd_idx == 6'(N_OUT - 1)) ? '0 : rd_idx + 6'd1;
               if (last_cap) begin
                  out_byte  <= pack_nxt;
                  out_valid <= 1'b1;
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  byte_cnt  <= last_out ? '0 : byte_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer1_host_if.sv
// Bench for layer1_host_if: table-driven frames, a mid-read reset, then random
// frames checked against a packing model and a start/done engine model.
`timescale 1ns/1ps
module tb_layer1_host_if;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_byte = '0;
   logic         in_ready;
   logic [127:0] pixels_flat;
   logic         l1_start;
   logic         l1_done;
   logic         l1_busy;
   logic [5:0]   l1_read_addr;
   logic [1:0]   l1_read_data;
   logic         out_valid;
   logic [7:0]   out_byte;
   logic         out_ready = 1'b0;
   logic         frame_done;

   int errors = 0;
   int checks = 0;

   logic [95:0] eng_codes = '0;
   int          done_lat  = 10;
   int          eng_cnt;
   logic        start_q = 1'b0;

   always #5 clk = ~clk;

   layer1_host_if #(.N_PIX(64), .N_OUT(48)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
      .pixels_flat(pixels_flat),
      .l1_start(l1_start), .l1_done(l1_done), .l1_busy(l1_busy),
      .l1_read_addr(l1_read_addr), .l1_read_data(l1_read_data),
      .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
      .frame_done(frame_done)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Engine: done rises done_lat cycles after start, held until start falls.
   assign l1_read_data = (l1_read_addr < 6'd48) ? eng_codes[2*int'(l1_read_addr) +: 2] : 2'b00;
   assign l1_busy      = l1_start & ~l1_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l1_done <= 1'b0;
         eng_cnt <= 0;
      end else if (l1_start && !l1_done) begin
         if (eng_cnt >= done_lat - 1) l1_done <= 1'b1;
         else                         eng_cnt <= eng_cnt + 1;
      end else if (!l1_start && l1_done) begin
         l1_done <= 1'b0;
         eng_cnt <= 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n && l1_start && !start_q) chk("start_rise_while_done", l1_done, 1'b0);
      start_q = rst_n & l1_start;
   end

   typedef struct {
      logic [127:0] in_bytes;   // byte k at [8k+7:8k]
      logic [95:0]  codes;      // engine output i at [2i+1:2i]
      int           stall_byte;
      int           stall_len;
      int           lat;
      bit           junk;       // keep offering bytes outside LOAD
      logic [127:0] exp_pix;
      logic [95:0]  exp_stream;
   } frame_t;

   task automatic run_frame(input frame_t f, input int abort_addr);
      logic [95:0] got;
      logic [7:0]  hb;
      logic [5:0]  ha;
      bit          ok;
      int          n;
      got = '0;
      eng_codes = f.codes;
      done_lat  = f.lat;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 15) begin
            chk("l1_start_during_load", l1_start, 1'b0);
            chk("in_ready_during_load", in_ready, 1'b1);
         end
         in_valid = 1'b1;
         in_byte  = f.in_bytes[8*k +: 8];
      end
      @(negedge clk);
      in_valid = f.junk;
      in_byte  = 8'hA5;
      chk("l1_start_after_16th", l1_start, 1'b1);
      chk("in_ready_in_start", in_ready, 1'b0);
      chk("pixels_flat", pixels_flat, f.exp_pix);

      n = 0; ok = 1;
      while (!l1_done && n < f.lat + 20) begin
         if (l1_read_addr !== 6'd0) ok = 0;
         @(negedge clk); n++;
      end
      if (!l1_done) begin chk("done_timeout", 1'b0, 1'b1); return; end
      chk("l1_start_held_on_done", l1_start, 1'b1);
      @(negedge clk);
      chk("l1_start_drop", l1_start, 1'b0);
      n = 0;
      while (l1_done && n < 20) begin
         if (l1_read_addr !== 6'd0) ok = 0;
         @(negedge clk); n++;
      end
      chk("read_addr_zero_until_done_low", ok, 1'b1);
      in_valid = 1'b0;

      if (abort_addr >= 0) begin
         out_ready = 1'b1;
         n = 0;
         while (int'(l1_read_addr) != abort_addr && n < 200) begin @(negedge clk); n++; end
         chk("abort_addr_reached", l1_read_addr, 6'(abort_addr));
         #2 rst_n = 1'b0;
         #1;
         chk("rst_in_ready", in_ready, 1'b1);
         chk("rst_l1_start", l1_start, 1'b0);
         chk("rst_read_addr", l1_read_addr, 6'd0);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_byte", out_byte, 8'h00);
         chk("rst_frame_done", frame_done, 1'b0);
         chk("rst_pixels", pixels_flat, 128'h0);
         out_ready = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end

      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      chk("first_byte_latency_ge5", (n >= 5), 1'b1);
      for (int j = 0; j < 12; j++) begin
         n = 0;
         while (!out_valid && n < 50) begin @(negedge clk); n++; end
         if (!out_valid) begin chk("out_valid_timeout", 1'b0, 1'b1); return; end
         if (j == f.stall_byte) begin
            hb = out_byte; ha = l1_read_addr; ok = 1;
            repeat (f.stall_len) begin
               @(negedge clk);
               if (!out_valid || out_byte !== hb || l1_read_addr !== ha) ok = 0;
            end
            chk("stall_stable", ok, 1'b1);
         end
         out_ready = 1'b1;
         #1;
         chk("frame_done", frame_done, (j == 11));
         got[8*j +: 8] = out_byte;
         @(negedge clk);
         out_ready = 1'b0;
         chk("out_valid_drop", out_valid, 1'b0);
      end
      chk("out_stream", got, f.exp_stream);
      chk("in_ready_after_frame", in_ready, 1'b1);
      chk("frame_done_idle", frame_done, 1'b0);
   endtask

   function automatic frame_t random_frame();
      frame_t f;
      int b [16];
      int c [48];
      f.exp_pix = '0; f.exp_stream = '0; f.in_bytes = '0; f.codes = '0;
      for (int k = 0; k < 16; k++) begin
         b[k] = int'($urandom_range(0, 255));
         f.in_bytes[8*k +: 8] = 8'(b[k]);
         f.exp_pix = f.exp_pix | (128'(b[k]) << (8*k));
      end
      for (int i = 0; i < 48; i++) begin
         c[i] = int'($urandom_range(0, 3));
         f.codes[2*i +: 2] = 2'(c[i]);
      end
      for (int j = 0; j < 12; j++) begin
         int v;
         v = c[4*j] + 4*c[4*j+1] + 16*c[4*j+2] + 64*c[4*j+3];
         f.exp_stream = f.exp_stream | (96'(v) << (8*j));
      end
      f.stall_byte = int'($urandom_range(0, 11));
      f.stall_len  = int'($urandom_range(1, 6));
      f.lat        = int'($urandom_range(1, 40));
      f.junk       = 1'($urandom_range(0, 1));
      return f;
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t tbl [2];
      tbl[0] = '{in_bytes: 128'h0F0E0D0C0B0A09080706050403020100,
                 codes: 96'hDDDDDDDDDDDDDDDDDDDDDDDD,
                 stall_byte: -1, stall_len: 0, lat: 3216, junk: 1'b0,
                 exp_pix: 128'h0F0E0D0C0B0A09080706050403020100,
                 exp_stream: 96'hDDDDDDDDDDDDDDDDDDDDDDDD};
      tbl[1] = '{in_bytes: 128'hFFEEDDCCBBAA99887766554433221100,
                 codes: 96'h777777777777777777777777,
                 stall_byte: 3, stall_len: 5, lat: 40, junk: 1'b1,
                 exp_pix: 128'hFFEEDDCCBBAA99887766554433221100,
                 exp_stream: 96'h777777777777777777777777};

      #12;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_l1_start", l1_start, 1'b0);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_byte", out_byte, 8'h00);
      chk("reset_read_addr", l1_read_addr, 6'd0);
      chk("reset_frame_done", frame_done, 1'b0);
      chk("reset_pixels", pixels_flat, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 2; r++) run_frame(tbl[r], -1);

      run_frame(tbl[1], 20);
      run_frame(tbl[0], -1);

      for (int r = 0; r < 4; r++) run_frame(random_frame(), -1);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
